mouse_cmd_sequencer: RTL and testbench
======================================

MOUSE_CMD_SEQUENCER -- requirements
Module: mouse_cmd_sequencer

Interface
REQ-001 Parameter SAMPLE_RATE, 8'd100, sample-rate byte sent after 0xF3.
REQ-002 Parameter RESOLUTION, 8'd2, resolution byte sent after 0xE8.
REQ-003 Parameter MAX_RETRY, 3, maximum retries per command byte before FAIL.
REQ-004 Parameter ACK_TIMEOUT, 5_000_000, CLK cycles allowed for BYTE_SENT or a single response byte.
REQ-005 Parameter BAT_TIMEOUT, 100_000_000, CLK cycles allowed for the 0xAA self-test byte.
REQ-006 Ports (name direction width meaning):
- CLK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to run the configuration sequence.
- SEND_BYTE  out  1  one-cycle pulse to the transmitter.
- BYTE_TO_SEND  out  8  byte for the transmitter, stable from SEND_BYTE until BYTE_SENT.
- BYTE_SENT  in  1  transmitter completion pulse.
- READ_ENABLE  out  1  receiver enable.
- BYTE_READ  in  8  received byte.
- BYTE_ERROR_CODE  in  2  receiver error, 0 = good.
- BYTE_READY  in  1  received-byte-valid pulse.
- BUSY  out  1  high in every state except IDLE, DONE and FAIL.
- DONE  out  1  level, sequence completed; cleared by START.
- FAIL  out  1  level, retries exhausted; cleared by START.
- STATE_CODE  out  4  current state encoding, debug.

Function
REQ-007 Byte list, in order: 0xFF, 0xF3, SAMPLE_RATE, 0xE8, RESOLUTION, 0xF4; byte index 0..5.
REQ-008 States and STATE_CODE: IDLE=0, SEND=1, WAIT_SENT=2, WAIT_ACK=3, WAIT_BAT=4, WAIT_ID=5, DONE=6, FAIL=7.
REQ-009 START transitions: IDLE, DONE or FAIL -> SEND; index and retry count cleared; START while BUSY ignored.
REQ-010 SEND: drive BYTE_TO_SEND = list[index]; SEND_BYTE high exactly one cycle, the cycle after START is sampled; next state WAIT_SENT.
REQ-011 WAIT_SENT: BYTE_SENT -> WAIT_ACK; BYTE_READY ignored.
REQ-012 READ_ENABLE is high only in WAIT_ACK, WAIT_BAT and WAIT_ID.
REQ-013 WAIT_ACK, BYTE_READY with error code 0: 0xFA -> WAIT_BAT if index 0, else index+1 and SEND; index 5 acked -> DONE.
REQ-014 Retry condition: 0xFE, any other byte, nonzero error code, or timeout.
REQ-015 On retry: retry count +1 and re-enter SEND with the same index, except a data byte (index 2 or 4), which restarts at its opcode (index-1).
REQ-016 Retry count reaching MAX_RETRY+1 -> FAIL instead of SEND.
REQ-017 Retry count clears on each successful ack.
REQ-018 WAIT_BAT: 0xAA -> WAIT_ID; WAIT_ID: 0x00 -> index 1 and SEND; any other byte, error or timeout -> retry from index 0.
REQ-019 Timeout counter reloads on every state entry and counts in WAIT_SENT/ACK/ID (ACK_TIMEOUT) and WAIT_BAT (BAT_TIMEOUT).
REQ-020 Counter width is sized by $clog2 of the larger timeout; a timeout fires on the cycle the count equals the limit.
REQ-021 DONE is a level in state DONE; FAIL is a level in state FAIL; both hold until START.
REQ-022 BYTE_SENT or BYTE_READY arriving in IDLE, DONE or FAIL has no effect.
REQ-023 All outputs are registered.

Reset
REQ-024 RESET_N low asynchronously forces IDLE, index=0, retries=0, timer=0.
REQ-025 RESET_N low forces all outputs 0, including mid-transfer.
REQ-026 The first START after RESET_N rises restarts from index 0.

Configuration
REQ-027 The macro MOUSE_SEQ_BAT_CHECK_EN enables the self-test check.
REQ-028 Defined: the ack of 0xFF enters WAIT_BAT/WAIT_ID per REQ-018.
REQ-029 Undefined: the ack of 0xFF goes directly to index 1 and SEND; WAIT_BAT and WAIT_ID are unreachable and their codes unused.

Structure
REQ-030 Shared package mouse_pkg holds: CMD_RESET=0xFF, CMD_SET_RATE=0xF3, CMD_SET_RES=0xE8, CMD_ENABLE=0xF4, RSP_ACK=0xFA, RSP_RESEND=0xFE, RSP_BAT_OK=0xAA, RSP_ID=0x00, and the state-code typedef.
REQ-031 One sub-module, mouse_timeout_counter (load, limit, expired), is instantiated once.

Verification
REQ-032 Nominal with BAT check: START; model answers FA, AA, 00, then FA x5 -> bytes FF,F3,64,E8,02,F4 sent in order; DONE=1 and BUSY=0 after the last FA.
REQ-033 Resend: answer FE to byte 0x64 -> 0xF3 resent, then 0x64; retry count returns to 0 after ack; DONE=1.
REQ-034 Exhaustion: MAX_RETRY=3, never send BYTE_READY after 0xF4 -> four ACK_TIMEOUT expiries, FAIL=1, STATE_CODE=7; a following START restarts from 0xFF.
REQ-035 Error code: BYTE_READY with code 2 and byte FA at index 3 -> 0xE8 resent; no index advance.
REQ-036 Reset mid-op: RESET_N low during WAIT_SENT -> same cycle all outputs 0 and STATE_CODE=0; START after release sends 0xFF.
REQ-037 Macro undefined: FA to 0xFF -> SEND of 0xF3 the following cycle; no wait for 0xAA.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, state encoding and byte-list helpers for the PS/2 mouse
// command sequencer.
package mouse_pkg;

  // Host-to-mouse command opcodes
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES  = 8'hE8;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Mouse-to-host response bytes
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  // Position of the final byte (enable reporting) in the configuration list
  localparam logic [2:0] LAST_INDEX = 3'd5;

  // State encoding; the numeric values are exported on STATE_CODE
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND      = 4'd1,
    ST_WAIT_SENT = 4'd2,
    ST_WAIT_ACK  = 4'd3,
    ST_WAIT_BAT  = 4'd4,
    ST_WAIT_ID   = 4'd5,
    ST_DONE      = 4'd6,
    ST_FAIL      = 4'd7
  } stateCode_t;

  // Byte transmitted at a given list position
  function automatic logic [7:0] byteAt(input logic [2:0] index,
                                        input logic [7:0] sampleRate,
                                        input logic [7:0] resolution);
    logic [7:0] value;
    case (index)
      3'd0:    value = CMD_RESET;
      3'd1:    value = CMD_SET_RATE;
      3'd2:    value = sampleRate;
      3'd3:    value = CMD_SET_RES;
      3'd4:    value = resolution;
      3'd5:    value = CMD_ENABLE;
      default: value = CMD_RESET;
    endcase
    return value;
  endfunction

  // Argument bytes cannot be resent on their own: the mouse forgets the
  // pending opcode after a resend, so the whole opcode/argument pair repeats
  function automatic logic isDataIndex(input logic [2:0] index);
    return (index == 3'd2) || (index == 3'd4);
  endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// Timeout counter for the mouse command sequencer. Cleared by load,
// advances while enabled, and flags expiry on the cycle the count equals
// the supplied limit. The count parks at the limit so it never wraps.
module mouse_timeout_counter #(
  parameter int WIDTH = 27
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Restart from zero on every state entry, otherwise count up to the limit
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = enable && (count == limit);

endmodule

// File: rtl/mouse_cmd_sequencer.sv
// PS/2 mouse configuration sequencer: sends FF, F3, rate, E8, resolution, F4,
// waits for an acknowledge after each byte and retries on failures.
// Build option: define MOUSE_SEQ_BAT_CHECK_EN to wait for the 0xAA self-test
// result and the 0x00 device ID after the reset command is acknowledged.
module mouse_cmd_sequencer
  import mouse_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100,
  parameter logic [7:0] RESOLUTION  = 8'd2,
  parameter int         MAX_RETRY   = 3,
  parameter int         ACK_TIMEOUT = 5_000_000,
  parameter int         BAT_TIMEOUT = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [3:0] STATE_CODE
);

  // The counter must be able to hold the larger limit value itself
  localparam int MAX_TIMEOUT = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int TIMER_W     = $clog2(MAX_TIMEOUT + 1);
  localparam int RETRY_W     = $clog2(MAX_RETRY + 2);

  localparam logic [TIMER_W-1:0] ACK_LIMIT  = TIMER_W'(ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0] BAT_LIMIT  = TIMER_W'(BAT_TIMEOUT);
  localparam logic [RETRY_W-1:0] RETRY_FAIL = RETRY_W'(MAX_RETRY + 1);

  stateCode_t         state;
  stateCode_t         nextState;
  logic [2:0]         index;
  logic [2:0]         nextIndex;
  logic [RETRY_W-1:0] retryCount;
  logic [RETRY_W-1:0] nextRetry;
  logic [RETRY_W-1:0] retryInc;
  logic               goodByte;
  logic               doRetry;

  logic               timerLoad;
  logic               timerEnable;
  logic [TIMER_W-1:0] timerLimit;
  logic               timerExpired;

  logic               sendByteD;
  logic [7:0]         byteToSendD;
  logic               readEnableD;
  logic               busyD;
  logic               doneD;
  logic               failD;

  assign retryInc = retryCount + RETRY_W'(1);

  // Reload on any state change; only the waiting states consume time, and
  // the self-test wait gets the long limit because BAT can take ~1 s
  assign timerLoad   = (nextState != state);
  assign timerEnable = (state == ST_WAIT_SENT) || (state == ST_WAIT_ACK) ||
                       (state == ST_WAIT_BAT)  || (state == ST_WAIT_ID);
  assign timerLimit  = (state == ST_WAIT_BAT) ? BAT_LIMIT : ACK_LIMIT;

  mouse_timeout_counter #(
    .WIDTH(TIMER_W)
  ) timeoutCounter (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .load   (timerLoad),
    .enable (timerEnable),
    .limit  (timerLimit),
    .expired(timerExpired)
  );

  // State, byte index and retry count registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      index      <= '0;
      retryCount <= '0;
    end else begin
      state      <= nextState;
      index      <= nextIndex;
      retryCount <= nextRetry;
    end
  end

  // Next-state decision, including the shared retry/fail path
  always_comb begin
    nextState = state;
    nextIndex = index;
    nextRetry = retryCount;
    goodByte  = BYTE_READY && (BYTE_ERROR_CODE == 2'd0);
    doRetry   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (START) begin
          nextState = ST_SEND;
          nextIndex = '0;
          nextRetry = '0;
        end
      end

      ST_SEND: begin
        nextState = ST_WAIT_SENT;
      end

      ST_WAIT_SENT: begin
        if (BYTE_SENT) begin
          nextState = ST_WAIT_ACK;
        end else if (timerExpired) begin
          doRetry = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          if (goodByte && (BYTE_READ == RSP_ACK)) begin
            nextRetry = '0;
            if (index == 3'd0) begin
`ifdef MOUSE_SEQ_BAT_CHECK_EN
              nextState = ST_WAIT_BAT;
`else
              nextIndex = 3'd1;
              nextState = ST_SEND;
`endif
            end else if (index == LAST_INDEX) begin
              nextState = ST_DONE;
            end else begin
              nextIndex = index + 3'd1;
              nextState = ST_SEND;
            end
          end else begin
            doRetry = 1'b1;
          end
        end else if (timerExpired) begin
          doRetry = 1'b1;
        end
      end

`ifdef MOUSE_SEQ_BAT_CHECK_EN
      ST_WAIT_BAT: begin
        if (BYTE_READY) begin
          if (goodByte && (BYTE_READ == RSP_BAT_OK)) begin
            nextState = ST_WAIT_ID;
          end else begin
            doRetry = 1'b1;
          end
        end else if (timerExpired) begin
          doRetry = 1'b1;
        end
      end

      ST_WAIT_ID: begin
        if (BYTE_READY) begin
          if (goodByte && (BYTE_READ == RSP_ID)) begin
            nextIndex = 3'd1;
            nextState = ST_SEND;
          end else begin
            doRetry = 1'b1;
          end
        end else if (timerExpired) begin
          doRetry = 1'b1;
        end
      end
`endif

      default: begin
        nextState = ST_IDLE;
      end
    endcase

    if (doRetry) begin
      nextRetry = retryInc;
      if (retryInc == RETRY_FAIL) begin
        nextState = ST_FAIL;
      end else begin
        nextState = ST_SEND;
        nextIndex = isDataIndex(index) ? (index - 3'd1) : index;
      end
    end
  end

  // Output values for the state being entered, so the registered outputs
  // line up with the state register
  always_comb begin
    sendByteD   = (nextState == ST_SEND);
    readEnableD = (nextState == ST_WAIT_ACK) || (nextState == ST_WAIT_BAT) ||
                  (nextState == ST_WAIT_ID);
    busyD       = (nextState != ST_IDLE) && (nextState != ST_DONE) &&
                  (nextState != ST_FAIL);
    doneD       = (nextState == ST_DONE);
    failD       = (nextState == ST_FAIL);
    byteToSendD = BYTE_TO_SEND;
    if (nextState == ST_SEND) begin
      byteToSendD = byteAt(nextIndex, SAMPLE_RATE, RESOLUTION);
    end
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
      READ_ENABLE  <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FAIL         <= 1'b0;
      STATE_CODE   <= 4'd0;
    end else begin
      SEND_BYTE    <= sendByteD;
      BYTE_TO_SEND <= byteToSendD;
      READ_ENABLE  <= readEnableD;
      BUSY         <= busyD;
      DONE         <= doneD;
      FAIL         <= failD;
      STATE_CODE   <= 4'(nextState);
    end
  end

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
// Self-checking bench for mouse_cmd_sequencer: a vector table of
// start/transfer/response steps, then hand-written retry exhaustion,
// restart and mid-transfer reset sequences. Follows MOUSE_SEQ_BAT_CHECK_EN.
module tb_mouse_cmd_sequencer;

  localparam int ACK_TO     = 20;
  localparam int BAT_TO     = 40;
  localparam int WAIT_LIMIT = 200;

`ifdef MOUSE_SEQ_BAT_CHECK_EN
  localparam logic [3:0] AFTER_RESET_ACK = 4'd4;
`else
  localparam logic [3:0] AFTER_RESET_ACK = 4'd1;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [3:0] STATE_CODE;

  typedef enum logic [1:0] {OP_START, OP_XFER, OP_RSP} op_t;

  typedef struct {
    op_t        op;
    logic [7:0] expSent;
    logic [7:0] rsp;
    logic [1:0] err;
    logic [3:0] expState;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  mouse_cmd_sequencer #(
    .SAMPLE_RATE(8'd100),
    .RESOLUTION (8'd2),
    .MAX_RETRY  (3),
    .ACK_TIMEOUT(ACK_TO),
    .BAT_TIMEOUT(BAT_TO)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .START          (START),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY     (BYTE_READY),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .FAIL           (FAIL),
    .STATE_CODE     (STATE_CODE)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Hard stop in case a sequence wedges
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pulseStart();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic pulseSent();
    @(negedge CLK);
    BYTE_SENT = 1'b1;
    @(negedge CLK);
    BYTE_SENT = 1'b0;
  endtask

  task automatic respond(input logic [7:0] value, input logic [1:0] err);
    BYTE_READ       = value;
    BYTE_ERROR_CODE = err;
    BYTE_READY      = 1'b1;
    @(negedge CLK);
    BYTE_READY      = 1'b0;
    BYTE_READ       = 8'h00;
    BYTE_ERROR_CODE = 2'd0;
  endtask

  task automatic waitSend(output logic [7:0] value, output int cycles);
    cycles = 0;
    while (SEND_BYTE !== 1'b1 && cycles < WAIT_LIMIT) begin
      @(negedge CLK);
      cycles++;
    end
    checkOutput("sendSeen", 32'(SEND_BYTE), 32'd1);
    value = BYTE_TO_SEND;
  endtask

  task automatic applyStimulus(input op_t op, input logic [7:0] expSent,
                               input logic [7:0] rsp, input logic [1:0] err,
                               input logic [3:0] expState, input int idx);
    logic [7:0] value;
    int         cycles;
    case (op)
      OP_START: begin
        pulseStart();
        checkOutput($sformatf("vec%0d.startSend", idx), 32'(SEND_BYTE), 32'd1);
      end
      OP_XFER: begin
        waitSend(value, cycles);
        checkOutput($sformatf("vec%0d.sentByte", idx), 32'(value), 32'(expSent));
        pulseSent();
        checkOutput($sformatf("vec%0d.ackState", idx), 32'(STATE_CODE), 32'd3);
        checkOutput($sformatf("vec%0d.readEnable", idx), 32'(READ_ENABLE), 32'd1);
        respond(rsp, err);
      end
      OP_RSP: begin
        respond(rsp, err);
      end
    endcase
    checkOutput($sformatf("vec%0d.state", idx), 32'(STATE_CODE), 32'(expState));
    if (expState == 4'd6) begin
      checkOutput($sformatf("vec%0d.done", idx), 32'(DONE), 32'd1);
      checkOutput($sformatf("vec%0d.busy", idx), 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] value;
    int         cycles;

    RESET_N         = 1'b0;
    START           = 1'b0;
    BYTE_SENT       = 1'b0;
    BYTE_READ       = 8'h00;
    BYTE_ERROR_CODE = 2'd0;
    BYTE_READY      = 1'b0;

    // Nominal run: every byte acknowledged first time
    vecs.push_back('{OP_START, 8'h00, 8'h00, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hFF, 8'hFA, 2'd0, AFTER_RESET_ACK});
`ifdef MOUSE_SEQ_BAT_CHECK_EN
    vecs.push_back('{OP_RSP,   8'h00, 8'hAA, 2'd0, 4'd5});
    vecs.push_back('{OP_RSP,   8'h00, 8'h00, 2'd0, 4'd1});
`endif
    vecs.push_back('{OP_XFER,  8'hF3, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'h64, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hE8, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'h02, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hF4, 8'hFA, 2'd0, 4'd6});

    // Retries: junk and resend on F3, resend on the rate byte (restarts at
    // F3), error code on E8. Four retries in total, so the run only reaches
    // DONE if each acknowledge clears the retry count.
    vecs.push_back('{OP_START, 8'h00, 8'h00, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hFF, 8'hFA, 2'd0, AFTER_RESET_ACK});
`ifdef MOUSE_SEQ_BAT_CHECK_EN
    vecs.push_back('{OP_RSP,   8'h00, 8'hAA, 2'd0, 4'd5});
    vecs.push_back('{OP_RSP,   8'h00, 8'h00, 2'd0, 4'd1});
`endif
    vecs.push_back('{OP_XFER,  8'hF3, 8'h12, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hF3, 8'hFE, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hF3, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'h64, 8'hFE, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hF3, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'h64, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hE8, 8'hFA, 2'd2, 4'd1});
    vecs.push_back('{OP_XFER,  8'hE8, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'h02, 8'hFA, 2'd0, 4'd1});
    vecs.push_back('{OP_XFER,  8'hF4, 8'hFA, 2'd0, 4'd6});

    repeat (3) @(negedge CLK);
    checkOutput("resetOutputs",
                32'({SEND_BYTE, READ_ENABLE, BUSY, DONE, FAIL, BYTE_TO_SEND, STATE_CODE}), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("idleState", 32'(STATE_CODE), 32'd0);
    checkOutput("idleBusy", 32'(BUSY), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].expSent, vecs[i].rsp, vecs[i].err,
                    vecs[i].expState, i);
    end

    // Stray receiver and transmitter pulses in DONE change nothing
    respond(8'hFA, 2'd0);
    BYTE_SENT = 1'b1;
    @(negedge CLK);
    BYTE_SENT = 1'b0;
    checkOutput("doneIgnoresState", 32'(STATE_CODE), 32'd6);
    checkOutput("doneIgnoresLevel", 32'(DONE), 32'd1);

    // Exhaustion: mouse never answers the enable command
    applyStimulus(OP_START, 8'h00, 8'h00, 2'd0, 4'd1, 100);
    applyStimulus(OP_XFER, 8'hFF, 8'hFA, 2'd0, AFTER_RESET_ACK, 101);
`ifdef MOUSE_SEQ_BAT_CHECK_EN
    applyStimulus(OP_RSP, 8'h00, 8'hAA, 2'd0, 4'd5, 102);
    applyStimulus(OP_RSP, 8'h00, 8'h00, 2'd0, 4'd1, 103);
`else
    waitSend(value, cycles);
    checkOutput("noBatWaitCycles", 32'(cycles), 32'd0);
    checkOutput("noBatWaitByte", 32'(value), 32'hF3);
`endif
    applyStimulus(OP_XFER, 8'hF3, 8'hFA, 2'd0, 4'd1, 104);
    applyStimulus(OP_XFER, 8'h64, 8'hFA, 2'd0, 4'd1, 105);
    applyStimulus(OP_XFER, 8'hE8, 8'hFA, 2'd0, 4'd1, 106);
    applyStimulus(OP_XFER, 8'h02, 8'hFA, 2'd0, 4'd1, 107);
    for (int i = 0; i < 4; i++) begin
      waitSend(value, cycles);
      checkOutput($sformatf("exhaust%0d.sent", i), 32'(value), 32'hF4);
      pulseSent();
      cycles = 0;
      while (SEND_BYTE !== 1'b1 && FAIL !== 1'b1 && cycles < WAIT_LIMIT) begin
        @(negedge CLK);
        cycles++;
      end
      checkOutput($sformatf("exhaust%0d.latency", i), 32'(cycles), 32'(ACK_TO + 1));
      if (i < 3) begin
        checkOutput($sformatf("exhaust%0d.resend", i), 32'(SEND_BYTE), 32'd1);
      end else begin
        checkOutput("exhaustFail", 32'(FAIL), 32'd1);
        checkOutput("exhaustState", 32'(STATE_CODE), 32'd7);
        checkOutput("exhaustBusy", 32'(BUSY), 32'd0);
      end
    end

    // START from FAIL restarts at the reset command
    pulseStart();
    checkOutput("restartState", 32'(STATE_CODE), 32'd1);
    waitSend(value, cycles);
    checkOutput("restartByte", 32'(value), 32'hFF);

    // Reset while waiting for the transmitter
    @(negedge CLK);
    checkOutput("midWaitSent", 32'(STATE_CODE), 32'd2);
    RESET_N = 1'b0;
    #1;
    checkOutput("midResetOutputs",
                32'({SEND_BYTE, READ_ENABLE, BUSY, DONE, FAIL, BYTE_TO_SEND, STATE_CODE}), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    pulseStart();
    waitSend(value, cycles);
    checkOutput("postResetCycles", 32'(cycles), 32'd0);
    checkOutput("postResetByte", 32'(value), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
